// File: rtl/outinf_pkg.sv
// Shared definitions for the outinf_stream output interface.
//   - default parameter constants used by outinf_stream and px_fifo
//   - clog2_safe: ceil(log2(v)), never smaller than 1, for pointer sizing
package outinf_pkg;

  localparam int XB_DEF    = 10;
  localparam int YB_DEF    = 10;
  localparam int PB_DEF    = 8;
  localparam int CH_DEF    = 1;
  localparam int DEPTH_DEF = 16;
  localparam int AF_DEF    = 2;

  function automatic int clog2_safe(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/outinf_stream_px_fifo.sv
// px_fifo: synchronous DEPTH-entry FIFO with combinational read data.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers only)
//   clr          synchronous clear of both pointers
//   push, din    write strobe and data (ignored when full)
//   pop          read strobe (ignored when empty); dout shows the head entry
//   full, empty  status
//   count        entries held, 0..DEPTH
module px_fifo
  import outinf_pkg::*;
#(
  parameter int W     = PB_DEF * CH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = clog2_safe(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/outinf_stream.sv
// outinf_stream: buffers an unthrottled pixel stream and presents it on a
// valid/ready output with row/frame position flags.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush              synchronous clear of FIFO, output stage, counters, overflow
//   cfg_width/height   beats per row / rows per frame (0 treated as 1)
//   pix_data, pix_en   input beat and strobe (no backpressure; dropped when full)
//   px_out_*           output beat, valid, ready, last-of-row, in-last-row
//   done               one-cycle pulse after the final beat of a frame transfers
//   out_inf_busy       occupancy within AF entries of DEPTH
//   overflow           sticky: an input beat was dropped
//   level              beats held (FIFO + output register)
// Handshake: a beat transfers on a rising edge where px_out_valid and
// px_out_ready are both 1; px_out_valid is a register output and never looks
// at px_out_ready, and a presented beat holds still until it transfers.
module outinf_stream
  import outinf_pkg::*;
#(
  parameter int XB    = XB_DEF,
  parameter int YB    = YB_DEF,
  parameter int PB    = PB_DEF,
  parameter int CH    = CH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AF    = AF_DEF,
  localparam int AW   = clog2_safe(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [XB-1:0]    cfg_width,
  input  logic [YB-1:0]    cfg_height,
  input  logic [CH*PB-1:0] pix_data,
  input  logic             pix_en,
  input  logic             px_out_ready,
  output logic [CH*PB-1:0] px_out_data,
  output logic             px_out_valid,
  output logic             px_out_last_x,
  output logic             px_out_last_y,
  output logic             done,
  output logic             out_inf_busy,
  output logic             overflow,
  output logic [LW-1:0]    level
);

  logic [CH*PB-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic             push;
  logic             pop;
  logic             load;
  logic             xfer;
  logic [XB-1:0]    col;
  logic [YB-1:0]    row;
  logic [XB-1:0]    w_sh;
  logic [YB-1:0]    h_sh;
  logic [XB-1:0]    w_eff;
  logic [YB-1:0]    h_eff;
  logic             at_last_x;
  logic             at_last_y;

  // Full is sampled before any same-cycle pop: a full FIFO refuses the beat.
  assign push = pix_en & ~fifo_full & ~flush;
  assign xfer = px_out_valid & px_out_ready;
  // Output register accepts a new beat when it is empty or being drained.
  assign load = ~px_out_valid | px_out_ready;
  assign pop  = load & ~fifo_empty & ~flush;

  px_fifo #(.W(CH*PB), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (pix_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_out_valid <= 1'b0;
      px_out_data  <= '0;
    end else if (flush) begin
      px_out_valid <= 1'b0;
      px_out_data  <= '0;
    end else if (load) begin
      px_out_valid <= ~fifo_empty;
      if (!fifo_empty) px_out_data <= fifo_dout;
    end
  end

  assign w_eff     = (cfg_width == '0) ? XB'(1) : cfg_width;
  assign h_eff     = (cfg_height == '0) ? YB'(1) : cfg_height;
  assign at_last_x = (col == w_sh - XB'(1));
  assign at_last_y = (row == h_sh - YB'(1));

  // Shadow geometry: follows cfg only while parked at a frame start, so a
  // mid-frame change takes effect from the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sh <= w_eff;
      h_sh <= h_eff;
    end else if (col == '0 && row == '0 && !xfer) begin
      w_sh <= w_eff;
      h_sh <= h_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      col      <= '0;
      row      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= xfer & at_last_x & at_last_y;
      if (pix_en && fifo_full) overflow <= 1'b1;
      if (xfer) begin
        if (at_last_x) begin
          col <= '0;
          row <= at_last_y ? '0 : row + YB'(1);
        end else begin
          col <= col + XB'(1);
        end
      end
    end
  end

  assign px_out_last_x = px_out_valid & at_last_x;
  assign px_out_last_y = px_out_valid & at_last_y;
  // Never exceeds DEPTH+1, which fits in LW bits.
  assign level         = LW'(fifo_count) + LW'(px_out_valid);
  assign out_inf_busy  = (level >= LW'(DEPTH - AF));

endmodule

// File: tb/tb_outinf_stream.sv
module tb_outinf_stream;

  localparam int XB    = 10;
  localparam int YB    = 10;
  localparam int PB    = 8;
  localparam int CH    = 1;
  localparam int DEPTH = 16;
  localparam int AF    = 2;
  localparam int DW    = CH * PB;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [XB-1:0] cfg_width = 10'd4;
  logic [YB-1:0] cfg_height = 10'd2;
  logic [DW-1:0] pix_data = '0;
  logic          pix_en = 1'b0;
  logic          px_out_ready = 1'b0;
  logic [DW-1:0] px_out_data;
  logic          px_out_valid;
  logic          px_out_last_x;
  logic          px_out_last_y;
  logic          done;
  logic          out_inf_busy;
  logic          overflow;
  logic [LW-1:0] level;

  outinf_stream #(
    .XB(XB), .YB(YB), .PB(PB), .CH(CH), .DEPTH(DEPTH), .AF(AF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .pix_data      (pix_data),
    .pix_en        (pix_en),
    .px_out_ready  (px_out_ready),
    .px_out_data   (px_out_data),
    .px_out_valid  (px_out_valid),
    .px_out_last_x (px_out_last_x),
    .px_out_last_y (px_out_last_y),
    .done          (done),
    .out_inf_busy  (out_inf_busy),
    .overflow      (overflow),
    .level         (level)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds every beat the block owns, oldest first; m_pres says whether
  // the oldest one is currently presented on the output.
  logic [DW-1:0] exp_q[$];
  bit            m_pres;
  bit            m_ovf;
  bit            m_done;
  int            m_k;        // beats already transferred in current frame
  int            m_w;
  int            m_h;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pres = 0;
    m_ovf  = 0;
    m_done = 0;
    m_k    = 0;
    m_w    = eff(int'(cfg_width));
    m_h    = eff(int'(cfg_height));
  endtask

  task automatic check_outputs();
    bit lx, ly;
    lx = (m_k % m_w) == m_w - 1;
    ly = (m_k / m_w) == m_h - 1;
    check_eq("valid", 32'(px_out_valid), 32'(m_pres));
    if (m_pres) check_eq("data", 32'(px_out_data), 32'(exp_q[0]));
    check_eq("last_x", 32'(px_out_last_x), 32'(m_pres && lx));
    check_eq("last_y", 32'(px_out_last_y), 32'(m_pres && ly));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("level", 32'(level), 32'(exp_q.size()));
    check_eq("busy", 32'(out_inf_busy), 32'(exp_q.size() >= DEPTH - AF));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: advance the model with the inputs as driven, then check.
  task automatic step();
    int fifo_cnt;
    bit xfer, lx, ly, new_pres;
    @(posedge clk);
    fifo_cnt = exp_q.size() - int'(m_pres);
    xfer     = m_pres && px_out_ready;
    lx       = (m_k % m_w) == m_w - 1;
    ly       = (m_k / m_w) == m_h - 1;
    if (m_k == 0 && !xfer) begin
      m_w = eff(int'(cfg_width));
      m_h = eff(int'(cfg_height));
    end
    if (flush) begin
      exp_q.delete();
      m_pres = 0;
      m_ovf  = 0;
      m_done = 0;
      m_k    = 0;
    end else begin
      m_done   = xfer && lx && ly;
      new_pres = (m_pres && !px_out_ready) ? 1'b1 : (fifo_cnt > 0);
      if (xfer) begin
        void'(exp_q.pop_front());
        m_k = (m_k + 1 == m_w * m_h) ? 0 : m_k + 1;
      end
      if (pix_en) begin
        if (fifo_cnt == DEPTH) m_ovf = 1;
        else exp_q.push_back(pix_data);
      end
      m_pres = new_pres;
    end
    #1;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit rdy);
    pix_en       = en;
    pix_data     = DW'($urandom);
    px_out_ready = rdy;
    step();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, rdy);
  endtask

  task automatic do_flush();
    flush  = 1'b1;
    pix_en = 1'b0;
    step();
    flush  = 1'b0;
  endtask

  int done_seen;

  initial begin
    // ---- reset ----
    model_reset();
    #1;
    check_eq("rst_valid", 32'(px_out_valid), 0);
    check_eq("rst_data", 32'(px_out_data), 0);
    check_eq("rst_last_x", 32'(px_out_last_x), 0);
    check_eq("rst_last_y", 32'(px_out_last_y), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_busy", 32'(out_inf_busy), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_level", 32'(level), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // ---- W=4 H=2 frame, ready high, 8 back-to-back beats ----
    done_seen = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      done_seen += int'(done);
    end
    check_eq("frame_done_count", 32'(done_seen), 1);

    // ---- fill with ready low: busy, overflow, level saturation ----
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
    check_eq("fill_level", 32'(level), 17);
    check_eq("fill_overflow", 32'(overflow), 1);
    check_eq("fill_busy", 32'(out_inf_busy), 1);
    idle(20, 1'b1);

    // ---- stall pattern 1,0,0,1 with valid high ----
    do_flush();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
    end
    idle(20, 1'b1);

    // ---- mid-frame width change 4 -> 2 ----
    do_flush();
    cfg_width  = 10'd4;
    cfg_height = 10'd2;
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    cfg_width = 10'd2;
    for (int i = 0; i < 13; i++) drive(1'b1, 1'b1);
    idle(4, 1'b1);

    // ---- flush with 5 buffered and pix_en high ----
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);   // overflow not expected; just one more beat
    flush    = 1'b1;
    pix_en   = 1'b1;
    pix_data = DW'($urandom);
    step();
    flush = 1'b0;
    check_eq("flush_valid", 32'(px_out_valid), 0);
    check_eq("flush_level", 32'(level), 0);
    check_eq("flush_overflow", 32'(overflow), 0);
    idle(2, 1'b1);

    // ---- randomized traffic with occasional cfg changes and flushes ----
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        cfg_width  = XB'($urandom_range(0, 5));
        cfg_height = YB'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) do_flush();
      else drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
    end
    idle(DEPTH + 4, 1'b1);

    // ---- async reset mid-row ----
    cfg_width  = 10'd4;
    cfg_height = 10'd2;
    do_flush();
    idle(2, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(px_out_valid), 0);
    check_eq("arst_data", 32'(px_out_data), 0);
    check_eq("arst_last_x", 32'(px_out_last_x), 0);
    check_eq("arst_last_y", 32'(px_out_last_y), 0);
    check_eq("arst_done", 32'(done), 0);
    check_eq("arst_level", 32'(level), 0);
    check_eq("arst_busy", 32'(out_inf_busy), 0);
    pix_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("arst_done_after", 32'(done), 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1);
      done_seen += int'(done);
    end
    check_eq("post_rst_done_count", 32'(done_seen), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/outinf_stream.md
OUTINF_STREAM -- requirements
Module: outinf_stream

Interface
REQ-001 Parameter XB, default 10: width of the column counter and cfg_width, in bits.
REQ-002 Parameter YB, default 10: width of the row counter and cfg_height, in bits.
REQ-003 Parameter PB, default 8: bits per pixel.
REQ-004 Parameter CH, default 1: pixels per beat (lanes); lane 0 occupies bits [PB-1:0].
REQ-005 Parameter DEPTH, default 16: FIFO entries, a power of two and at least 4.
REQ-006 Parameter AF, default 2: almost-full margin, in entries.
REQ-007 clk  in  1  single clock; all state is sampled on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 flush  in  1  synchronous clear of FIFO, counters and error state.
REQ-010 cfg_width  in  XB  beats per row.
REQ-011 cfg_height  in  YB  rows per frame.
REQ-012 pix_data  in  CH*PB  input beat.
REQ-013 pix_en  in  1  input beat strobe; there is no input backpressure.
REQ-014 px_out_ready  in  1  downstream ready.
REQ-015 px_out_data  out  CH*PB  output beat.
REQ-016 px_out_valid  out  1  output beat valid.
REQ-017 px_out_last_x  out  1  presented beat is the last beat of its row.
REQ-018 px_out_last_y  out  1  presented beat is in the last row of the frame.
REQ-019 done  out  1  one-cycle frame-complete pulse.
REQ-020 out_inf_busy  out  1  FIFO almost full.
REQ-021 overflow  out  1  sticky: a beat was dropped.
REQ-022 level  out  $clog2(DEPTH)+1  occupancy (FIFO plus output register).

Function
REQ-023 Push: a beat is written when pix_en=1 and the FIFO is not full; full is evaluated before any same-cycle pop, so a push into a full FIFO is refused even if a pop occurs that cycle.
REQ-024 pix_en=1 while full: the beat is dropped and overflow is set on the next edge; overflow stays set until flush or reset.
REQ-025 Output stage: a registered skid stage that loads from the FIFO whenever it is empty or is being transferred.
REQ-026 Transfer: a beat transfers in a cycle where px_out_valid=1 and px_out_ready=1.
REQ-027 While px_out_valid=1 and px_out_ready=0, px_out_data, px_out_last_x and px_out_last_y hold stable.
REQ-028 px_out_valid never depends combinationally on px_out_ready.
REQ-029 Latency: a beat pushed into an empty block at edge N is presented with px_out_valid=1 after edge N+1.
REQ-030 With ready held high, the block sustains one beat per cycle.
REQ-031 Column counter col (XB bits) advances on each transfer and wraps to 0 after the last beat of a row.
REQ-032 Row counter row (YB bits) advances on each row wrap and wraps to 0 after the last row.
REQ-033 Effective width W is max(cfg_width,1); effective height H is max(cfg_height,1).
REQ-034 Shadow configuration: W and H reload from the cfg inputs on every cycle in which col=0, row=0 and no transfer occurs; they are frozen otherwise, so a mid-frame cfg change applies from the next frame.
REQ-035 px_out_last_x = px_out_valid and (col = W-1).
REQ-036 px_out_last_y = px_out_valid and (row = H-1).
REQ-037 done pulses high for exactly one cycle, on the edge after the transfer of the beat carrying last_x=1 and last_y=1.
REQ-038 out_inf_busy = (level >= DEPTH-AF).
REQ-039 flush=1: FIFO, output register, counters and overflow clear on the next edge; a pix_en in the same cycle is discarded.
REQ-040 flush has priority over all other activity in that cycle.
REQ-041 Occupancy arithmetic does not wrap: level saturates at DEPTH+1, and the count is exact by construction.

Reset
REQ-042 rst_n=0 asynchronously clears all of: FIFO pointers, output register valid, col, row, overflow, done.
REQ-043 While rst_n=0, the shadow W and H are loaded from the cfg inputs.
REQ-044 Reset values: px_out_valid=0, px_out_last_x=0, px_out_last_y=0, done=0, out_inf_busy=0, overflow=0, level=0, px_out_data=0.
REQ-045 Reset asserted mid-frame abandons the frame; no done pulse is produced for it.

Structure
REQ-046 Shared package outinf_pkg holds the default parameter constants and a function clog2_safe.
REQ-047 Sub-module px_fifo: a synchronous DEPTH x (CH*PB) FIFO with full, empty and count outputs.
REQ-048 The skid stage and the counters live in outinf_stream.

Verification
REQ-049 W=4, H=2, CH=1, ready=1, 8 beats pushed back-to-back: 8 valid cycles; last_x on beats 4 and 8; last_y on beats 5-8; done high for one cycle after beat 8.
REQ-050 DEPTH=16, AF=2, ready=0, 20 beats pushed: busy rises when level reaches 14; overflow set after beat 18; level=17; the first 17 beats drain in order.
REQ-051 ready toggling 1,0,0,1 with valid high: data and flags stable across the stall cycles; no beat duplicated or lost.
REQ-052 cfg_width changed from 4 to 2 mid-frame: the current frame completes with W=4; the next frame shows last_x every 2 beats.
REQ-053 flush asserted with 5 beats buffered and pix_en=1: after the edge, valid=0, level=0, col=row=0, overflow=0.
REQ-054 rst_n pulsed low mid-row: outputs take their reset values immediately, without waiting for a clock edge; no done pulse; the next frame starts at col=0, row=0.
